ov7670_stream_gen: RTL

Synthesisable OV7670 sensor emulator that drives vsync, href and an 8-bit data bus with the same byte-serial RGB444 timing the camera produces. It is the transmit end of the pixel interface that the capture block receives. Its outputs feed the capture path in place of the real camera pins, for on-board bring-up and simulation without a sensor. It produces selectable test patterns, and frame counts are reported back to the design.

---
 rtl/ov7670_stream_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670 RGB444 byte-serial sensor emulator with selectable test patterns
module ov7670_stream_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 510
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_color,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int BW = $clog2(2 * H_TOTAL + 1);
    localparam int LW = $clog2(V_TOTAL + 1);

    localparam logic [BW-1:0] BYTE_LAST = BW'(2 * H_TOTAL - 1);
    localparam logic [BW-1:0] BYTE_ACT  = BW'(2 * H_ACTIVE);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL - 1);
    localparam logic [LW-1:0] LINE_SYNC = LW'(V_SYNC);
    localparam logic [LW-1:0] LINE_ACT0 = LW'(V_SYNC + V_BACK);
    localparam logic [LW-1:0] LINE_ACT1 = LW'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [15:0]   BAR_W     = 16'(H_ACTIVE / 8);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]    state;
    logic [BW-1:0] byte_cnt;
    logic [LW-1:0] line_cnt;
    logic [1:0]    pat_q;
    logic [11:0]   solid_q;

    logic          last_byte;
    logic          last_line;
    logic          active;
    logic [15:0]   x;
    logic [3:0]    y;
    logic [2:0]    bar;
    logic [11:0]   rgb;
    logic [7:0]    pix;

    always_comb begin
        last_byte = (byte_cnt == BYTE_LAST);
        last_line = (line_cnt == LINE_LAST);
        active    = (line_cnt >= LINE_ACT0) && (line_cnt < LINE_ACT1) && (byte_cnt < BYTE_ACT);
        x         = 16'(byte_cnt >> 1);
        y         = 4'(line_cnt - LINE_ACT0);
        bar       = 3'(x / BAR_W);
        rgb       = 12'h000;
        case (pat_q)
            2'd0: begin
                case (bar)
                    3'd0:    rgb = 12'hFFF;
                    3'd1:    rgb = 12'hFF0;
                    3'd2:    rgb = 12'h0FF;
                    3'd3:    rgb = 12'h0F0;
                    3'd4:    rgb = 12'hF0F;
                    3'd5:    rgb = 12'hF00;
                    3'd6:    rgb = 12'h00F;
                    default: rgb = 12'h000;
                endcase
            end
            2'd1:    rgb = {x[3:0], y, x[3:0] ^ y};
            2'd2:    rgb = solid_q;
            default: rgb = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
        endcase
        // Even byte carries red alone, odd byte carries green/blue
        pix = byte_cnt[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            pat_q      <= 2'd0;
            solid_q    <= 12'h000;
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            vsync      <= 1'b0;
            href       <= 1'b0;
            d          <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (enable) begin
                    state    <= ST_FRAME;
                    byte_cnt <= '0;
                    line_cnt <= '0;
                    pat_q    <= pattern_sel;
                    solid_q  <= solid_color;
                end
            end else begin
                busy  <= 1'b1;
                vsync <= (line_cnt < LINE_SYNC);
                href  <= active;
                d     <= active ? pix : 8'h00;
                if (last_byte) begin
                    byte_cnt <= '0;
                    if (last_line) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        line_cnt   <= '0;
                        // enable and pattern are only looked at here, so a frame is never cut short
                        if (enable) begin
                            pat_q   <= pattern_sel;
                            solid_q <= solid_color;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end
endmodule
